// File: rtl/mac_count6_tc.sv
// 6-bit loadable up-counter with IDLE/RUN/HALT control, terminal count and carry pulse.
// Optional reload register on wrap: define MAC_COUNT6_RELOAD_EN.
module mac_count6_tc (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] D,
  input  logic       LD,
  input  logic       WR,
  input  logic       CE,
  input  logic       ONESHOT,
  output logic [5:0] Q,
  output logic       TC,
  output logic       CO,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [5:0] q_nxt;
  logic [5:0] wrap_val;
  logic       wrap;

  assign TC   = &Q;
  assign BUSY = (state == RUN);
  // LD outranks CE, so a load at terminal count is not a wrap.
  assign wrap = BUSY & CE & TC & ~LD;

`ifdef MAC_COUNT6_RELOAD_EN
  logic [5:0] rl;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   rl <= '0;
    else if (WR) rl <= D;
  end

  assign wrap_val = rl;
`else
  logic unused_wr;

  assign unused_wr = WR;
  assign wrap_val  = '0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      Q     <= '0;
      CO    <= 1'b0;
    end else begin
      state <= state_nxt;
      Q     <= q_nxt;
      CO    <= wrap;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = Q;
    case (state)
      IDLE, HALT: begin
        if (LD) begin
          state_nxt = RUN;
          q_nxt     = D;
        end
      end
      RUN: begin
        if (LD) begin
          q_nxt = D;
        end else if (wrap) begin
          // One-shot parks at 63; free-run restarts from the wrap value.
          if (ONESHOT) state_nxt = HALT;
          else         q_nxt     = wrap_val;
        end else if (CE) begin
          q_nxt = Q + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_count6_tc.sv
// Directed bench for mac_count6_tc: integer reference model checked every cycle
// plus hand-computed expectations along each scenario.
module tb_mac_count6_tc;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] D;
  logic       LD, WR, CE, ONESHOT;
  logic [5:0] Q;
  logic       TC, CO, BUSY;

  int checks = 0;
  int errors = 0;

`ifdef MAC_COUNT6_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  mac_count6_tc dut (
    .CLK(CLK), .RESET(RESET), .D(D), .LD(LD), .WR(WR), .CE(CE),
    .ONESHOT(ONESHOT), .Q(Q), .TC(TC), .CO(CO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: m_mode 0 = waiting for load, 1 = counting, 2 = one-shot expired.
  int m_q, m_rl, m_mode;
  bit m_co;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_q <= 0; m_rl <= 0; m_mode <= 0; m_co <= 1'b0;
    end else begin
      m_co <= 1'b0;
      if (RELOAD && WR) m_rl <= int'(D);
      if (LD) begin
        m_q <= int'(D); m_mode <= 1;
      end else if (m_mode == 1 && CE) begin
        if (m_q == 63) begin
          m_co <= 1'b1;
          if (ONESHOT) m_mode <= 2;
          else         m_q <= RELOAD ? m_rl : 0;
        end else begin
          m_q <= (m_q + 1) % 64;
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model comparison on every falling edge, away from the active edge.
  always @(negedge CLK) begin
    check("model_q",    int'(Q),    m_q);
    check("model_tc",   int'(TC),   (m_q == 63) ? 1 : 0);
    check("model_co",   int'(CO),   int'(m_co));
    check("model_busy", int'(BUSY), (m_mode == 1) ? 1 : 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input int q, input int co, input int busy);
    check({name, "_q"},    int'(Q),    q);
    check({name, "_co"},   int'(CO),   co);
    check({name, "_busy"}, int'(BUSY), busy);
    check({name, "_tc"},   int'(TC),   (q == 63) ? 1 : 0);
  endtask

  int wrap_exp;

  initial begin
    RESET = 1'b1; D = '0; LD = 0; WR = 0; CE = 0; ONESHOT = 0;
    tick(); tick();
    expect_out("reset", 0, 0, 0);
    RESET = 1'b0;

    // CE in IDLE must not count
    CE = 1; tick(); tick();
    expect_out("idle_ce", 0, 0, 0);

    // CE toggling 1,0,1 from Q=0
    LD = 1; D = 6'd0; tick();
    expect_out("ld0", 0, 0, 1);
    LD = 0; CE = 1; tick(); expect_out("ce1", 1, 0, 1);
    CE = 0;         tick(); expect_out("ce0", 1, 0, 1);
    CE = 1;         tick(); expect_out("ce1b", 2, 0, 1);

    // free-run wrap from 60, RL still 0
    ONESHOT = 0; LD = 1; D = 6'd60; CE = 0; tick();
    expect_out("ld60", 60, 0, 1);
    LD = 0; CE = 1;
    tick(); expect_out("run61", 61, 0, 1);
    tick(); expect_out("run62", 62, 0, 1);
    tick(); expect_out("run63", 63, 0, 1);
    tick(); expect_out("wrap0", 0, 1, 1);
    tick(); expect_out("run1", 1, 0, 1);

    // LD at terminal count beats CE: no wrap, no CO
    LD = 1; D = 6'd63; tick();
    expect_out("ld63", 63, 0, 1);
    D = 6'd10; tick();
    expect_out("ld_over_wrap", 10, 0, 1);
    LD = 0; tick();
    expect_out("after_ld10", 11, 0, 1);

    // one-shot: halts at 63 with a single CO pulse
    ONESHOT = 1; LD = 1; D = 6'd62; tick();
    expect_out("os_ld62", 62, 0, 1);
    LD = 0;
    tick(); expect_out("os63", 63, 0, 1);
    tick(); expect_out("os_halt", 63, 1, 0);
    ONESHOT = 0;
    tick(); expect_out("os_hold1", 63, 0, 0);
    tick(); expect_out("os_hold2", 63, 0, 0);
    LD = 1; D = 6'd5; tick();
    expect_out("os_reload5", 5, 0, 1);
    LD = 0; CE = 0;

    // reload register: wrap lands on RL only in the reload build
    wrap_exp = RELOAD ? 50 : 0;
    WR = 1; D = 6'd50; tick();
    expect_out("wr50", 5, 0, 1);
    WR = 0; LD = 1; D = 6'd62; CE = 1; tick();
    expect_out("rl_ld62", 62, 0, 1);
    LD = 0;
    tick(); expect_out("rl63", 63, 0, 1);
    tick(); expect_out("rl_wrap", wrap_exp, 1, 1);
    tick(); expect_out("rl_next", wrap_exp + 1, 0, 1);

    // simultaneous WR and LD take the same D
    wrap_exp = RELOAD ? 61 : 0;
    WR = 1; LD = 1; D = 6'd61; tick();
    expect_out("wrld61", 61, 0, 1);
    WR = 0; LD = 0;
    tick(); expect_out("wrld62", 62, 0, 1);
    tick(); expect_out("wrld63", 63, 0, 1);
    tick(); expect_out("wrld_wrap", wrap_exp, 1, 1);

    // asynchronous reset mid-count at Q=37
    CE = 0; LD = 1; D = 6'd37; tick();
    expect_out("ld37", 37, 0, 1);
    LD = 0;
    #2 RESET = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0);
    LD = 1; WR = 1; CE = 1; D = 6'd40;
    tick(); tick();
    expect_out("rst_hold", 0, 0, 0);
    LD = 0; WR = 0; CE = 0;
    RESET = 1'b0;
    tick(); expect_out("post_rst_idle", 0, 0, 0);
    LD = 1; D = 6'd3; tick();
    expect_out("post_rst_ld3", 3, 0, 1);
    LD = 0; CE = 1; tick();
    expect_out("post_rst_run", 4, 0, 1);
    CE = 0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
